// File: rtl/muxl2_tx_pkg.sv
// Shared definitions for the two-lane byte split/merge blocks:
// default bus width and FIFO depth, lane indices and the lane selector type.
package muxl2_tx_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    typedef enum logic {
        SEL_LANE0 = LANE0,
        SEL_LANE1 = LANE1
    } sel_e;

    function automatic sel_e other_lane(input sel_e s);
        return (s == SEL_LANE0) ? SEL_LANE1 : SEL_LANE0;
    endfunction

endpackage

// File: rtl/muxl2_tx_fifo_l2.sv
// fifo_l2: small synchronous FIFO used as the per-lane buffer of muxl2_tx.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
// dout always shows the head entry; it is meaningful only while empty is low.
module fifo_l2
    import muxl2_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: written only when a push is accepted; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/muxl2_tx.sv
// muxl2_tx: merges two byte lanes back into one registered byte stream.
// Each lane is buffered in a fifo_l2; the arbiter drains lane0, lane1, lane0, ...
// With STRICT=0 an empty expected lane is skipped when the other lane has data,
// and the selector keeps pointing at the skipped lane.
module muxl2_tx
    import muxl2_tx_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int STRICT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Entrada0,
    input  logic             validEntrada0,
    input  logic [WIDTH-1:0] Entrada1,
    input  logic             validEntrada1,
    output logic [WIDTH-1:0] Salida,
    output logic             validsalida,
    output logic             fifo_full0,
    output logic             fifo_full1,
    output logic             overflow0,
    output logic             overflow1
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    sel_e             sel;
    sel_e             sel_next;

    logic             pop0;
    logic             pop1;
    logic [WIDTH-1:0] dout0;
    logic [WIDTH-1:0] dout1;
    logic             empty0;
    logic             empty1;
    logic             full0;
    logic             full1;
    logic [AW:0]      count0;
    logic [AW:0]      count1;

    logic             sel_empty;
    logic             oth_empty;
    logic [WIDTH-1:0] sel_dout;
    logic [WIDTH-1:0] oth_dout;
    logic             take_sel;
    logic             take_oth;
    logic [WIDTH-1:0] out_data_next;
    logic             out_valid_next;

    logic             drop0;
    logic             drop1;

    fifo_l2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (validEntrada0),
        .pop   (pop0),
        .din   (Entrada0),
        .dout  (dout0),
        .empty (empty0),
        .full  (full0),
        .count (count0)
    );

    fifo_l2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (validEntrada1),
        .pop   (pop1),
        .din   (Entrada1),
        .dout  (dout1),
        .empty (empty1),
        .full  (full1),
        .count (count1)
    );

    assign fifo_full0 = full0;
    assign fifo_full1 = full1;

    assign drop0 = validEntrada0 && (count0 == CNT_FULL) && !pop0;
    assign drop1 = validEntrada1 && (count1 == CNT_FULL) && !pop1;

    // Arbiter: choose at most one lane to pop from registered occupancy, and
    // compute the next selector and the next output byte.
    always_comb begin
        sel_next       = sel;
        take_sel       = 1'b0;
        take_oth       = 1'b0;
        pop0           = 1'b0;
        pop1           = 1'b0;
        out_valid_next = 1'b0;
        out_data_next  = '0;

        sel_empty = (sel == SEL_LANE0) ? empty0 : empty1;
        oth_empty = (sel == SEL_LANE0) ? empty1 : empty0;
        sel_dout  = (sel == SEL_LANE0) ? dout0  : dout1;
        oth_dout  = (sel == SEL_LANE0) ? dout1  : dout0;

        if (!sel_empty) begin
            take_sel = 1'b1;
        end else if ((STRICT == 0) && !oth_empty) begin
            take_oth = 1'b1;
        end

        if (take_sel) begin
            out_valid_next = 1'b1;
            out_data_next  = sel_dout;
            sel_next       = other_lane(sel);
        end else if (take_oth) begin
            out_valid_next = 1'b1;
            out_data_next  = oth_dout;
        end

        pop0 = (take_sel && (sel == SEL_LANE0)) || (take_oth && (sel == SEL_LANE1));
        pop1 = (take_sel && (sel == SEL_LANE1)) || (take_oth && (sel == SEL_LANE0));
    end

    // Selector register: lane 0 is expected first after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= SEL_LANE0;
        end else begin
            sel <= sel_next;
        end
    end

    // Output register: an idle cycle drives zero rather than holding the last byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Salida      <= '0;
            validsalida <= 1'b0;
        end else begin
            Salida      <= out_data_next;
            validsalida <= out_valid_next;
        end
    end

    // Sticky drop flags: set when a lane byte cannot be buffered; cleared by reset only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow0 <= 1'b0;
            overflow1 <= 1'b0;
        end else begin
            if (drop0) begin
                overflow0 <= 1'b1;
            end
            if (drop1) begin
                overflow1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muxl2_tx.sv
// Testbench for muxl2_tx: one strict and one work-conserving instance share
// the same lane inputs. A queue-based lane model predicts each emitted byte and
// the cycle it appears; a negedge monitor checks every cycle against it.
module tb_muxl2_tx;

    localparam int W = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] e0 = 8'h00;
    logic [7:0] e1 = 8'h00;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;

    logic [7:0] sal [2];
    logic       val [2];
    logic       ff0 [2];
    logic       ff1 [2];
    logic       ov0 [2];
    logic       ov1 [2];

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    logic [7:0]  lq   [4][$];
    int unsigned expq [2][$];
    int          msel [2];
    bit          mfull[2][2];
    bit          movf [2][2];

    muxl2_tx #(.WIDTH(W), .DEPTH(D), .STRICT(1)) dut_strict (
        .clk           (clk),
        .reset         (reset),
        .Entrada0      (e0),
        .validEntrada0 (v0),
        .Entrada1      (e1),
        .validEntrada1 (v1),
        .Salida        (sal[0]),
        .validsalida   (val[0]),
        .fifo_full0    (ff0[0]),
        .fifo_full1    (ff1[0]),
        .overflow0     (ov0[0]),
        .overflow1     (ov1[0])
    );

    muxl2_tx #(.WIDTH(W), .DEPTH(D), .STRICT(0)) dut_wc (
        .clk           (clk),
        .reset         (reset),
        .Entrada0      (e0),
        .validEntrada0 (v0),
        .Entrada1      (e1),
        .validEntrada1 (v1),
        .Salida        (sal[1]),
        .validsalida   (val[1]),
        .fifo_full0    (ff0[1]),
        .fifo_full1    (ff1[1]),
        .overflow0     (ov0[1]),
        .overflow1     (ov1[1])
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check(input string name, input int s, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s dut%0d got=%0h want=%0h cyc=%0d t=%0t", name, s, act, exp, cyc, $time);
        end
    endtask

    // One edge of the reference model: pop by occupancy before the edge, then push.
    task automatic modelStep(input int s);
        int         lane;
        logic [7:0] b;
        bit         vin [2];
        logic [7:0] din [2];
        vin[0] = v0;
        vin[1] = v1;
        din[0] = e0;
        din[1] = e1;
        lane = -1;
        if (lq[s*2 + msel[s]].size() > 0) begin
            lane = msel[s];
            msel[s] = 1 - msel[s];
        end else if (s == 1 && lq[s*2 + 1 - msel[s]].size() > 0) begin
            lane = 1 - msel[s];
        end
        if (lane >= 0) begin
            b = lq[s*2 + lane].pop_front();
            expq[s].push_back((cyc << 8) | 32'(b));
        end
        for (int n = 0; n < 2; n++) begin
            if (vin[n]) begin
                if (lq[s*2 + n].size() < D) lq[s*2 + n].push_back(din[n]);
                else movf[s][n] = 1'b1;
            end
            mfull[s][n] = (lq[s*2 + n].size() == D);
        end
    endtask

    // Reference model: cleared by reset, stepped on every rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                expq[s].delete();
                msel[s] = 0;
                for (int n = 0; n < 2; n++) begin
                    lq[s*2 + n].delete();
                    mfull[s][n] = 1'b0;
                    movf[s][n] = 1'b0;
                end
            end
        end else begin
            cyc++;
            for (int s = 0; s < 2; s++) modelStep(s);
        end
    end

    // Per-cycle comparison of one instance against its scoreboard entry.
    task automatic checkOutput(input int s);
        bit          exp_v;
        int unsigned e;
        exp_v = (expq[s].size() > 0) && ((expq[s][0] >> 8) == cyc);
        check("valid", s, 32'(val[s]), 32'(exp_v));
        if (exp_v) begin
            e = expq[s].pop_front();
            check("byte", s, 32'(sal[s]), e & 32'hFF);
        end else begin
            check("idle_zero", s, 32'(sal[s]), 0);
        end
        check("full0", s, 32'(ff0[s]), 32'(mfull[s][0]));
        check("full1", s, 32'(ff1[s]), 32'(mfull[s][1]));
        check("ovf0", s, 32'(ov0[s]), 32'(movf[s][0]));
        check("ovf1", s, 32'(ov1[s]), 32'(movf[s][1]));
    endtask

    // Monitor: sample both instances away from the active edge.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) checkOutput(s);
    end

    task automatic applyStimulus(input bit a, input logic [7:0] da, input bit b, input logic [7:0] db);
        @(negedge clk);
        v0 = a;
        e0 = da;
        v1 = b;
        e1 = db;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] reset then idle");
        idle(10);

        $display("[TB] balanced interleave");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 8'h00);
            applyStimulus(1'b0, 8'h00, 1'b1, 8'hB0 + 8'(i));
        end
        idle(6);

        $display("[TB] lane0 silent, lane1 waiting");
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hB0);
        idle(5);
        applyStimulus(1'b1, 8'hA0, 1'b0, 8'h00);
        idle(6);

        $display("[TB] lane0 overflow");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'h00);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 8'h10 + 8'(i));
            idle(1);
        end
        idle(6);
        check("ovf0_sticky", 0, 32'(ov0[0]), 1);

        $display("[TB] asynchronous reset mid-stream");
        doReset();
        applyStimulus(1'b1, 8'h50, 1'b1, 8'h60);
        applyStimulus(1'b1, 8'h51, 1'b1, 8'h61);
        applyStimulus(1'b1, 8'h52, 1'b1, 8'h62);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", s, 32'(val[s]), 0);
            check("rst_data", s, 32'(sal[s]), 0);
            check("rst_full0", s, 32'(ff0[s]), 0);
            check("rst_ovf0", s, 32'(ov0[s]), 0);
        end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        #2;
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hD0);
        applyStimulus(1'b1, 8'hC0, 1'b0, 8'h00);
        idle(6);

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 400; i++) begin
            int p;
            p = (i < 200) ? 40 : 85;
            applyStimulus($urandom_range(0, 99) < p, 8'($urandom),
                          $urandom_range(0, 99) < p, 8'($urandom));
        end
        idle(20);
        for (int s = 0; s < 2; s++) check("drained", s, expq[s].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
